// File: rtl/clz_normalizer.sv
// Multi-cycle leading-zero counter and left-normalizer for 32-bit operands.
// One binary-search stage per cycle (widths 16, 8, 4, 2, 1).
module clz_normalizer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [5:0]  count,
    output logic [31:0] norm
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  step_q, step_d;
    logic [31:0] w_q, w_d;
    logic [5:0]  c_q, c_d;
    logic [5:0]  count_q, count_d;
    logic [31:0] norm_q, norm_d;

    logic [5:0]  width;
    logic [31:0] top_mask;
    logic [31:0] w_stage;
    logic [5:0]  c_stage;

    // Stage k tests the top (16 >> k) bits and shifts them out if all zero.
    always_comb begin
        width    = 6'd16 >> step_q;
        top_mask = ~(32'hFFFF_FFFF >> width);
        w_stage  = w_q;
        c_stage  = c_q;
        if ((w_q & top_mask) == 32'd0) begin
            w_stage = w_q << width;
            c_stage = c_q + width;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        w_d     = w_q;
        c_d     = c_q;
        count_d = count_q;
        norm_d  = norm_q;
        if (flush) begin
            state_d = IDLE;
            step_d  = 3'd0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    state_d = IDLE;
                    if (start) begin
                        state_d = RUN;
                        step_d  = 3'd0;
                        w_d     = a;
                        c_d     = 6'd0;
                    end
                end
                RUN: begin
                    w_d = w_stage;
                    c_d = c_stage;
                    if (step_q == 3'd4) begin
                        // A zero operand never gets a 1 into bit 31.
                        count_d = w_stage[31] ? c_stage : 6'd32;
                        norm_d  = w_stage;
                        state_d = DONE;
                        step_d  = 3'd0;
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    step_d  = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            step_q  <= 3'd0;
            w_q     <= 32'd0;
            c_q     <= 6'd0;
            count_q <= 6'd0;
            norm_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            w_q     <= w_d;
            c_q     <= c_d;
            count_q <= count_d;
            norm_q  <= norm_d;
        end
    end

    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign count = count_q;
    assign norm  = norm_q;

endmodule

// File: tb/tb_clz_normalizer.sv
// Scoreboard bench for clz_normalizer: driver pushes reference results,
// a negedge monitor pops and compares on every done pulse.
module tb_clz_normalizer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic        flush;
    logic        busy;
    logic        done;
    logic [5:0]  count;
    logic [31:0] norm;

    int checks = 0;
    int errors = 0;
    logic [37:0] exp_q[$];

    clz_normalizer dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .count (count),
        .norm  (norm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [37:0] ref_model(input logic [31:0] v);
        int n;
        logic [31:0] r;
        n = 0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) break;
            n++;
        end
        r = (n == 32) ? 32'd0 : (v << n);
        return {6'(n), r};
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding result.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: count=%0d norm=%0h", count, norm);
            end else begin
                logic [37:0] e;
                e = exp_q.pop_front();
                check("count", 64'(count), 64'(e[37:32]));
                check("norm", 64'(norm), 64'(e[31:0]));
            end
        end
    end

    // Call at a negedge; returns just after the accepting edge.
    task automatic accept(input logic [31:0] v, input bit track);
        start = 1'b1;
        a     = v;
        @(posedge clk);
        if (track) exp_q.push_back(ref_model(v));
        #1;
        start = 1'b0;
        a     = $urandom;
    endtask

    // Checks busy for five cycles and done in the sixth; ends at that negedge.
    task automatic expect_latency(input bit poke_run);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check("busy_run", 64'(busy), 64'd1);
            check("done_run", 64'(done), 64'd0);
            if (poke_run) begin
                start = (i == 2 || i == 4);
                a     = $urandom;
            end
        end
        start = 1'b0;
        @(negedge clk);
        check("done_pulse", 64'(done), 64'd1);
        check("busy_done", 64'(busy), 64'd0);
    endtask

    task automatic op(input logic [31:0] v);
        accept(v, 1'b1);
        expect_latency(1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        int sh;
        reset = 1'b1;
        start = 1'b1;
        flush = 1'b1;
        a     = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_norm", 64'(norm), 64'd0);
        reset = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        @(negedge clk);

        op(32'h0000_0001);
        @(negedge clk);
        check("idle_after_done", 64'(done), 64'd0);
        op(32'h0000_0000);
        op(32'h8000_0000);
        op(32'h00F0_0000);
        op(32'h0000_ABCD);

        // Back-to-back: second start held during the DONE cycle.
        @(negedge clk);
        accept(32'h0000_0001, 1'b1);
        expect_latency(1'b1);
        accept(32'h4000_0000, 1'b1);
        expect_latency(1'b1);

        // Prime count/norm, then flush at step 2.
        accept(32'h8000_0000, 1'b1);
        expect_latency(1'b0);
        accept(32'h0000_0100, 1'b0);
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_done", 64'(done), 64'd0);
        check("flush_count", 64'(count), 64'd0);
        check("flush_norm", 64'(norm), 64'h8000_0000);
        repeat (8) @(negedge clk);
        check("flush_hold_count", 64'(count), 64'd0);
        start = 1'b1;
        flush = 1'b1;
        a     = 32'h1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check("start_flush_busy", 64'(busy), 64'd0);
        repeat (7) @(negedge clk);

        // Reset at step 3, then a normal operation.
        accept(32'h0000_0F00, 1'b0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_done", 64'(done), 64'd0);
        check("mrst_count", 64'(count), 64'd0);
        check("mrst_norm", 64'(norm), 64'd0);
        @(negedge clk);
        op(32'h0012_3456);

        for (int n = 0; n < 40; n++) begin
            sh = $urandom_range(0, 32);
            v  = (sh == 32) ? 32'd0 : ($urandom | 32'h8000_0000) >> sh;
            if ($urandom_range(0, 3) == 0) v = $urandom;
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
            accept(v, 1'b1);
            expect_latency(n[0]);
        end

        repeat (10) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
